// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the BCD-to-segment decoder.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // seg7_sel code of the rightmost digit on the reference board.
   localparam logic [2:0] DEFAULT_SEL_BASE = 3'b101;

   // Non-BCD codes decode to a dark digit rather than a misleading glyph.
   function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
      logic [6:0] seg;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit of the counter chain. en_in advances the digit one step
// up or down; carry_out tells the next digit to step as well (carry when
// counting up from 9, borrow when counting down from 0). load overrides
// counting and sanitises non-BCD data to 0.
module bcd_digit_updown (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_in,
   input  logic       up_down,
   input  logic       load,
   input  logic [3:0] load_digit,
   output logic [3:0] digit,
   output logic       carry_out
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Ripple to the next digit when this one is about to wrap.
   always_comb begin
      carry_out = en_in && (up_down ? (digit_q == 4'd9) : (digit_q == 4'd0));
   end

   // Next digit value: load first, then step, otherwise hold.
   always_comb begin
      digit_d = digit_q;
      if (load) begin
         digit_d = (load_digit > 4'd9) ? 4'd0 : load_digit;
      end else if (en_in) begin
         if (up_down) begin
            digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
         end else begin
            digit_d = ((digit_q == 4'd0) || (digit_q > 4'd9)) ? 4'd9 : digit_q - 4'd1;
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) digit_q <= 4'd0;
      else     digit_q <= digit_d;
   end

   assign digit = digit_q;

endmodule

// File: rtl/bcd_mux_counter.sv
// N-digit up/down BCD counter with parallel load, driving a multiplexed
// 7-segment display. Everything runs on clk; the count and scan rates come
// from free-running prescalers that emit one-cycle tick enables.
module bcd_mux_counter
   import seg7_pkg::*;
#(
   parameter int          NUM_DIGITS = 2,
   parameter int          COUNT_DIV  = 21,
   parameter int          SCAN_DIV   = 17,
   parameter logic [2:0]  SEL_BASE   = DEFAULT_SEL_BASE
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    up_down,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    blank_lz,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    carry,
   output logic [2:0]              seg7_sel,
   output logic [6:0]              seg7_out,
   output logic                    dpt_out,
   output logic                    led_com
);

   localparam logic [COUNT_DIV-1:0] CDIV_ONE = 1;
   localparam logic [SCAN_DIV-1:0]  SDIV_ONE = 1;
   localparam logic [2:0]           LAST_IDX = 3'(NUM_DIGITS - 1);

   logic [COUNT_DIV-1:0] cdiv_q, cdiv_d;
   logic [SCAN_DIV-1:0]  sdiv_q, sdiv_d;
   logic                 count_tick;
   logic                 scan_tick;
   logic [NUM_DIGITS:0]  chain;
   logic                 carry_q, carry_d;
   logic [2:0]           idx_q, idx_d;
   logic [2:0]           sel_q, sel_d;
   logic [6:0]           seg_q, seg_d;
   logic [3:0]           cur_digit;
   logic                 cur_blank;
   logic                 zero_run;

   // Prescalers: a tick is the single cycle in which the counter is all-ones.
   always_comb begin
      cdiv_d     = cdiv_q + CDIV_ONE;
      sdiv_d     = sdiv_q + SDIV_ONE;
      count_tick = &cdiv_q;
      scan_tick  = &sdiv_q;
   end

   // A load in the same cycle swallows the count tick, so it never ripples
   // into the chain and never produces a carry pulse.
   always_comb begin
      chain[0] = count_tick && enable && !load;
      carry_d  = chain[NUM_DIGITS];
   end

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_updown u_digit (
         .clk        (clk),
         .rst        (reset),
         .en_in      (chain[i]),
         .up_down    (up_down),
         .load       (load),
         .load_digit (load_value[4*i +: 4]),
         .digit      (count_bcd[4*i +: 4]),
         .carry_out  (chain[i+1])
      );
   end

   // Scan index walks 0..NUM_DIGITS-1 on each scan tick.
   always_comb begin
      idx_d = idx_q;
      if (scan_tick) begin
         idx_d = (idx_q >= LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      end
   end

   // Pick the scanned digit and decide blanking: a digit is a leading zero
   // when it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      zero_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (count_bcd[4*i +: 4] == 4'd0);
         if (idx_q == 3'(i)) begin
            cur_digit = count_bcd[4*i +: 4];
            cur_blank = blank_lz && zero_run && (i != 0);
         end
      end
      sel_d = SEL_BASE - idx_q;
      seg_d = cur_blank ? SEG_BLANK : seg7_decode(cur_digit);
   end

   // Prescalers, scan index, carry pulse and the display output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cdiv_q  <= '0;
         sdiv_q  <= '0;
         carry_q <= 1'b0;
         idx_q   <= 3'd0;
         sel_q   <= SEL_BASE;
         seg_q   <= SEG_0;
      end else begin
         cdiv_q  <= cdiv_d;
         sdiv_q  <= sdiv_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign carry    = carry_q;
   assign seg7_sel = sel_q;
   assign seg7_out = seg_q;
   assign dpt_out  = 1'b0;
   assign led_com  = 1'b1;

endmodule
